// File: rtl/traffic_phase_scheduler_if.sv
// ============================================================================
// Module      : traffic_phase_scheduler_if
// Description : Signal bundle between the intersection phase scheduler and
//               its surroundings.
//               slave  modport : used by the scheduler (inputs tick/requests,
//                                outputs lamps and status)
//               master modport : used by whoever drives tick and requests
//               Signals: tick, req_a, req_b, ped_req, [preempt_a],
//                        led[5:0], walk, ped_pending, phase[2:0]
//               Optional: PREEMPT_EN adds preempt_a.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface traffic_phase_scheduler_if;
    logic       tick;
    logic       req_a;
    logic       req_b;
    logic       ped_req;
`ifdef PREEMPT_EN
    logic       preempt_a;
`endif
    logic [5:0] led;
    logic       walk;
    logic       ped_pending;
    logic [2:0] phase;

`ifdef PREEMPT_EN
    modport master (
        output tick, req_a, req_b, ped_req, preempt_a,
        input  led, walk, ped_pending, phase
    );
    modport slave (
        input  tick, req_a, req_b, ped_req, preempt_a,
        output led, walk, ped_pending, phase
    );
`else
    modport master (
        output tick, req_a, req_b, ped_req,
        input  led, walk, ped_pending, phase
    );
    modport slave (
        input  tick, req_a, req_b, ped_req,
        output led, walk, ped_pending, phase
    );
`endif
endinterface

`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
// ============================================================================
// Module      : traffic_phase_scheduler
// Description : Tick-driven phase scheduler for a two-road intersection with
//               a pedestrian crossing. Runs on the system clock, advances
//               only on the one-cycle tick strobe.
// Ports       : clk  - system clock
//               rst  - asynchronous active-high reset
//               bus  - traffic_phase_scheduler_if.slave
//                      in : tick, req_a, req_b, ped_req, [preempt_a]
//                      out: led {A_r,A_y,A_g,B_r,B_y,B_g}, walk,
//                           ped_pending, phase
// Options     : PREEMPT_EN - adds preempt_a (emergency vehicle on road A)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_phase_scheduler #(
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALL_RED_T = 1,
    parameter int WALK_T    = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    traffic_phase_scheduler_if.slave bus
);

    localparam int TW = $clog2(MAX_GREEN + 1);

    // Durations pre-cast to the (timer+1) comparison width.
    localparam logic [TW:0] c_min_green = (TW+1)'(MIN_GREEN);
    localparam logic [TW:0] c_max_green = (TW+1)'(MAX_GREEN);
    localparam logic [TW:0] c_yellow_t  = (TW+1)'(YELLOW_T);
    localparam logic [TW:0] c_all_red_t = (TW+1)'(ALL_RED_T);
    localparam logic [TW:0] c_walk_t    = (TW+1)'(WALK_T);

    typedef enum logic [2:0] {
        A_GRN    = 3'd0,
        A_YEL    = 3'd1,
        B_GRN    = 3'd2,
        B_YEL    = 3'd3,
        ALL_RED  = 3'd4,
        PED_WALK = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [TW:0]   w_cnt;          // ticks in state including the current one
    logic          r_last_road;    // 0 = A served last, 1 = B served last
    logic          w_last_road_nxt;
    logic          r_prev_walk;    // previous state was PED_WALK
    logic          r_ped_pending;
    logic          w_illegal;
    logic          w_enter_walk;
    logic          w_pre;

`ifdef PREEMPT_EN
    assign w_pre = bus.preempt_a;
`else
    assign w_pre = 1'b0;
`endif

    assign w_cnt = {1'b0, r_timer} + (TW+1)'(1);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_last_road_nxt = r_last_road;
        w_illegal       = 1'b0;
        case (r_state)
            A_GRN: begin
                if (!w_pre && (w_cnt >= c_min_green) &&
                    (bus.req_b || r_ped_pending) &&
                    (!bus.req_a || (w_cnt >= c_max_green)))
                    w_state_nxt = A_YEL;
            end
            B_GRN: begin
                if (w_pre || ((w_cnt >= c_min_green) &&
                    (bus.req_a || r_ped_pending) &&
                    (!bus.req_b || (w_cnt >= c_max_green))))
                    w_state_nxt = B_YEL;
            end
            A_YEL: begin
                if (w_cnt >= c_yellow_t) begin
                    w_state_nxt     = ALL_RED;
                    w_last_road_nxt = 1'b0;
                end
            end
            B_YEL: begin
                if (w_cnt >= c_yellow_t) begin
                    w_state_nxt     = ALL_RED;
                    w_last_road_nxt = 1'b1;
                end
            end
            ALL_RED: begin
                if (w_cnt >= c_all_red_t) begin
                    if (w_pre)
                        w_state_nxt = A_GRN;
                    else if (r_ped_pending && !r_prev_walk)
                        w_state_nxt = PED_WALK;
                    else if (r_last_road)
                        w_state_nxt = A_GRN;
                    else
                        w_state_nxt = B_GRN;
                end
            end
            PED_WALK: begin
                if (w_cnt >= c_walk_t)
                    w_state_nxt = ALL_RED;
            end
            default: begin
                // Corrupted code: recover to the safe state without a tick.
                w_state_nxt = ALL_RED;
                w_illegal   = 1'b1;
            end
        endcase
    end

    assign w_enter_walk = bus.tick && (r_state == ALL_RED) && (w_state_nxt == PED_WALK);

    // ------------------------------------------------------------------
    // State, timer and history registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ALL_RED;
            r_timer     <= '0;
            r_last_road <= 1'b1;
            r_prev_walk <= 1'b0;
        end else if (bus.tick || w_illegal) begin
            if (w_state_nxt != r_state) begin
                r_state     <= w_state_nxt;
                r_timer     <= '0;
                r_last_road <= w_last_road_nxt;
                r_prev_walk <= (r_state == PED_WALK);
            end else if (r_timer != {TW{1'b1}}) begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

    // Pedestrian latch: the clear on walk entry dominates a new request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ped_pending <= 1'b0;
        else if (w_enter_walk)
            r_ped_pending <= 1'b0;
        else if (bus.ped_req)
            r_ped_pending <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        bus.led  = 6'b100_100;
        bus.walk = 1'b0;
        case (r_state)
            A_GRN:    bus.led = 6'b001_100;
            A_YEL:    bus.led = 6'b010_100;
            B_GRN:    bus.led = 6'b100_001;
            B_YEL:    bus.led = 6'b100_010;
            PED_WALK: bus.walk = 1'b1;
            default:  bus.led = 6'b100_100;
        endcase
    end

    assign bus.phase       = r_state;
    assign bus.ped_pending = r_ped_pending;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
// ============================================================================
// Module      : tb_traffic_phase_scheduler
// Description : Directed self-checking bench for traffic_phase_scheduler.
//               Ticks are issued every 10 clks; outputs are sampled on the
//               falling edge after each tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_phase_scheduler;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    traffic_phase_scheduler_if bus();

    traffic_phase_scheduler #(
        .MIN_GREEN (5),
        .MAX_GREEN (20),
        .YELLOW_T  (3),
        .ALL_RED_T (1),
        .WALK_T    (8)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One tick pulse after 9 idle clks; optional coincident ped_req.
    task automatic tick_p(input logic ped);
        repeat (9) @(negedge clk);
        bus.tick    = 1'b1;
        bus.ped_req = ped;
        @(negedge clk);
        bus.tick    = 1'b0;
        bus.ped_req = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_p(1'b0);
    endtask

    // One-clk ped_req between ticks.
    task automatic ped_pulse;
        @(negedge clk);
        bus.ped_req = 1'b1;
        @(negedge clk);
        bus.ped_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        bus.tick    = 1'b0;
        bus.req_a   = 1'b0;
        bus.req_b   = 1'b0;
        bus.ped_req = 1'b0;
`ifdef PREEMPT_EN
        bus.preempt_a = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_led",   8'(bus.led), 8'h24);
        chk("rst_phase", 8'(bus.phase), 8'd4);
        chk("rst_walk",  8'(bus.walk), 8'd0);
        chk("rst_pend",  8'(bus.ped_pending), 8'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("allred_led", 8'(bus.led), 8'h24);

        // First green is A, held with no competing request.
        tick_p(1'b0);
        chk("first_a_led", 8'(bus.led), 8'h0C);
        for (int i = 0; i < 50; i++) begin
            tick_p(1'b0);
            chk("hold_a", 8'(bus.phase), 8'd0);
        end

        // Saturated timer: req_b alone exits at once.
        bus.req_b = 1'b1;
        tick_p(1'b0);
        chk("a_yel_sat", 8'(bus.phase), 8'd1);
        chk("a_yel_led", 8'(bus.led), 8'h14);
        ticks(2);
        chk("a_yel_hold", 8'(bus.phase), 8'd1);
        tick_p(1'b0);
        chk("allred_after_a", 8'(bus.phase), 8'd4);
        tick_p(1'b0);
        chk("b_grn_led", 8'(bus.led), 8'h21);

        // Both requesting: B exits at MAX_GREEN.
        bus.req_a = 1'b1;
        ticks(19);
        chk("b_max_19", 8'(bus.phase), 8'd2);
        tick_p(1'b0);
        chk("b_max_20", 8'(bus.phase), 8'd3);
        ticks(3);
        chk("allred_b", 8'(bus.phase), 8'd4);
        tick_p(1'b0);
        chk("a_after_b", 8'(bus.phase), 8'd0);

        // Both requesting: A exits at MAX_GREEN.
        ticks(19);
        chk("a_max_19", 8'(bus.phase), 8'd0);
        tick_p(1'b0);
        chk("a_max_20", 8'(bus.phase), 8'd1);
        ticks(3);
        chk("allred_a", 8'(bus.phase), 8'd4);
        tick_p(1'b0);
        chk("b_after_a", 8'(bus.phase), 8'd2);

        // Competing side only: exit at MIN_GREEN.
        bus.req_b = 1'b0;
        ticks(4);
        chk("b_min_4", 8'(bus.phase), 8'd2);
        tick_p(1'b0);
        chk("b_min_5", 8'(bus.phase), 8'd3);
        chk("b_yel_led", 8'(bus.led), 8'h22);
        ticks(4);
        chk("a_again", 8'(bus.phase), 8'd0);

        // req_b pulsed on tick 2 only: below minimum, A holds.
        bus.req_a = 1'b0;
        tick_p(1'b0);
        bus.req_b = 1'b1;
        tick_p(1'b0);
        bus.req_b = 1'b0;
        ticks(6);
        chk("pulse_hold", 8'(bus.phase), 8'd0);

        // Pedestrian request from A_GRN.
        ped_pulse();
        chk("ped_latch", 8'(bus.ped_pending), 8'd1);
        tick_p(1'b0);
        chk("ped_a_yel", 8'(bus.phase), 8'd1);
        ticks(3);
        chk("ped_allred", 8'(bus.phase), 8'd4);
        tick_p(1'b0);
        chk("walk_phase", 8'(bus.phase), 8'd5);
        chk("walk_on", 8'(bus.walk), 8'd1);
        chk("walk_led", 8'(bus.led), 8'h24);
        chk("walk_clr", 8'(bus.ped_pending), 8'd0);
        ticks(7);
        chk("walk_7", 8'(bus.walk), 8'd1);
        tick_p(1'b0);
        chk("walk_off", 8'(bus.walk), 8'd0);
        chk("walk_allred", 8'(bus.phase), 8'd4);
        tick_p(1'b0);
        chk("b_after_walk", 8'(bus.phase), 8'd2);

        // ped_req coincident with walk entry, then re-latched mid-walk.
        ped_pulse();
        ticks(5);
        chk("ped_b_yel", 8'(bus.phase), 8'd3);
        ticks(3);
        chk("ped_allred2", 8'(bus.phase), 8'd4);
        tick_p(1'b1);
        chk("walk2_phase", 8'(bus.phase), 8'd5);
        chk("walk2_clr_wins", 8'(bus.ped_pending), 8'd0);
        ticks(3);
        ped_pulse();
        chk("relatch", 8'(bus.ped_pending), 8'd1);
        ticks(5);
        chk("walk2_end", 8'(bus.phase), 8'd4);
        tick_p(1'b0);
        chk("no_back2back", 8'(bus.phase), 8'd0);
        chk("still_pend", 8'(bus.ped_pending), 8'd1);
        ticks(5);
        chk("a_yel_ped", 8'(bus.phase), 8'd1);
        ticks(4);
        chk("walk3", 8'(bus.walk), 8'd1);
        ticks(9);
        chk("b_after_walk3", 8'(bus.phase), 8'd2);

        // Asynchronous reset during B_YEL, between ticks.
        bus.req_a = 1'b1;
        ticks(6);
        chk("pre_rst_byel", 8'(bus.phase), 8'd3);
        ped_pulse();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_led", 8'(bus.led), 8'h24);
        chk("arst_walk", 8'(bus.walk), 8'd0);
        chk("arst_phase", 8'(bus.phase), 8'd4);
        chk("arst_pend", 8'(bus.ped_pending), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        tick_p(1'b0);
        chk("post_rst_a", 8'(bus.phase), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
